// File: rtl/instr_mem_loader.sv
// Boot-time instruction memory loader: packs a valid/ready byte stream into little-endian words
// and writes them sequentially from address 0. Define INSTR_LOADER_CHECKSUM_EN for checksum checking.
module instr_mem_loader #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int SIZE          = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [SIZE:0]            word_count,
  input  logic                     byte_valid,
  input  logic [7:0]               byte_data,
  output logic                     byte_ready,
  output logic                     wr_en,
  output logic [ADDRESS_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0]    wr_data,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
`ifdef INSTR_LOADER_CHECKSUM_EN
    S_CHECK = 3'd3,
`endif
    S_DONE  = 3'd4
  } state_t;

  localparam logic [SIZE:0] CAPACITY = {1'b1, {SIZE{1'b0}}};

  state_t                   state_reg, state_next;
  logic [SIZE:0]            count_reg;
  logic [SIZE-1:0]          word_idx_reg;
  logic [1:0]               byte_idx_reg;
  logic [23:0]              shift_reg;
  logic [ADDRESS_WIDTH-1:0] wr_addr_reg, addr_next;
  logic [DATA_WIDTH-1:0]    wr_data_reg;
  logic                     error_reg;
  logic                     accept, last_byte, last_word;
  logic                     start_zero, start_over;
  logic [2:0]               lane_we;
  logic [31:0]              assembled;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [31:0]              sum_reg;
`endif

  assign accept     = byte_valid && byte_ready;
  assign last_byte  = accept && (byte_idx_reg == 2'd3);
  assign last_word  = ({1'b0, word_idx_reg} == (count_reg - 1'b1));
  assign start_zero = (word_count == '0);
  assign start_over = (word_count > CAPACITY);
  // The fourth byte is never stored; it goes straight into the assembled word.
  assign assembled  = {byte_data, shift_reg};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lane
      assign lane_we[gi] = accept && (byte_idx_reg == 2'(gi));
    end
  endgenerate

  always_comb begin
    addr_next = '0;
    addr_next[SIZE+1:0] = {word_idx_reg, 2'b00};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    byte_ready = 1'b0;
    wr_en      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = (start_zero || start_over) ? S_DONE : S_RECV;
        end
      end
      S_RECV: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (last_byte) begin
          state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        wr_en = 1'b1;
        busy  = 1'b1;
        if (last_word) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
          state_next = S_CHECK;
`else
          state_next = S_DONE;
`endif
        end else begin
          state_next = S_RECV;
        end
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      S_CHECK: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (last_byte) begin
          state_next = S_DONE;
        end
      end
`endif
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg    <= '0;
      word_idx_reg <= '0;
      byte_idx_reg <= '0;
      shift_reg    <= '0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
      error_reg    <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      sum_reg      <= '0;
`endif
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (lane_we[k]) begin
          shift_reg[8*k +: 8] <= byte_data;
        end
      end
      if (accept) begin
        byte_idx_reg <= byte_idx_reg + 1'b1;
      end
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            if (start_over) begin
              error_reg <= 1'b1;
            end else begin
              error_reg <= 1'b0;
            end
            if (!start_zero && !start_over) begin
              count_reg    <= word_count;
              word_idx_reg <= '0;
              byte_idx_reg <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
              sum_reg      <= '0;
`endif
            end
          end
        end
        S_RECV: begin
          if (last_byte) begin
            wr_data_reg <= DATA_WIDTH'(assembled);
            wr_addr_reg <= addr_next;
          end
        end
        S_WRITE: begin
          word_idx_reg <= word_idx_reg + 1'b1;
          byte_idx_reg <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
          sum_reg      <= sum_reg + 32'(wr_data_reg);
`endif
        end
`ifdef INSTR_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (last_byte && (assembled != sum_reg)) begin
            error_reg <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign wr_addr = wr_addr_reg;
  assign wr_data = wr_data_reg;
  assign error   = error_reg;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: directed boundaries plus random byte streams
// checked against a word-packing reference model.
module tb_instr_mem_loader;
  localparam int SZ = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [SZ:0] word_count = '0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready, wr_en, busy, done, error;
  logic [31:0] wr_addr, wr_data;

  instr_mem_loader #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .SIZE(SZ)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .word_count(word_count),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Bus observer
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  int done_n = 0, done_cyc = 0, last_wr_cyc = 0, last_acc_cyc = 0, ready_in_write = 0;
  always @(negedge clk) begin
    if (wr_en) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
      last_wr_cyc = cyc;
    end
    if (wr_en && byte_ready) ready_in_write++;
    if (done) begin
      done_n++;
      done_cyc = cyc;
    end
    if (byte_valid && byte_ready) last_acc_cyc = cyc;
  end

  logic [7:0] byte_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    done_n = 0;
    ready_in_write = 0;
  endtask

  task automatic pulse_start(input int n);
    word_count = (SZ+1)'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit got = 1'b0;
    if (gaps) begin
      while ($urandom_range(0, 2) == 0) begin
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
        @(posedge clk); #1;
      end
    end
    byte_valid = 1'b1;
    byte_data  = b;
    for (int w = 0; w < 40 && !got; w++) begin
      @(negedge clk);
      if (byte_ready) got = 1'b1;
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    check("byte_accepted", 64'(got), 64'd1);
  endtask

  task automatic fill_random(input int n);
    byte_q.delete();
    for (int i = 0; i < 4 * n; i++) byte_q.push_back(8'($urandom));
  endtask

  // Loads n words taken from byte_q; the model packs each group of four bytes little-endian.
  task automatic run_load(input int n, input bit gaps, input bit bad_sum);
    logic [31:0] exp_d[$];
    logic [31:0] sum = 32'd0;
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = 32'(byte_q[4*i]) + 32'(byte_q[4*i+1]) * 32'd256 +
          32'(byte_q[4*i+2]) * 32'd65536 + 32'(byte_q[4*i+3]) * 32'd16777216;
      exp_d.push_back(w);
      sum = sum + w;
    end
    clear_log();
    pulse_start(n);
    check("busy_after_start", 64'(busy), 64'd1);
    check("error_cleared", 64'(error), 64'd0);
    for (int i = 0; i < 4 * n; i++) begin
      send_byte(byte_q[i], gaps);
      if (gaps && i == 1) begin
        word_count = (SZ+1)'(1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
`ifdef INSTR_LOADER_CHECKSUM_EN
    if (bad_sum) sum = sum + 32'd1;
    for (int k = 0; k < 4; k++) send_byte(8'(sum >> (8 * k)), gaps);
`endif
    for (int t = 0; t < 20 && done_n == 0; t++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    check("write_count", 64'(wa_q.size()), 64'(n));
    for (int i = 0; i < n && i < wa_q.size(); i++) begin
      check("wr_addr", 64'(wa_q[i]), 64'(i * 4));
      check("wr_data", 64'(wd_q[i]), 64'(exp_d[i]));
    end
    check("done_pulses", 64'(done_n), 64'd1);
    check("error_final", 64'(error), 64'(bad_sum));
    check("ready_in_write", 64'(ready_in_write), 64'd0);
`ifdef INSTR_LOADER_CHECKSUM_EN
    check("done_timing", 64'(done_cyc), 64'(last_acc_cyc + 1));
`else
    check("done_timing", 64'(done_cyc), 64'(last_wr_cyc + 1));
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_byte_ready"}, 64'(byte_ready), 64'd0);
    check({tag, "_wr_en"}, 64'(wr_en), 64'd0);
    check({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
    check({tag, "_wr_data"}, 64'(wr_data), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_error"}, 64'(error), 64'd0);
  endtask

  initial begin
    #3;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic directed load
    byte_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_load(2, 1'b0, 1'b0);
    check("basic_word0", 64'(wd_q.size() > 0 ? wd_q[0] : 32'hdead), 64'h00000013);
    check("basic_word1", 64'(wd_q.size() > 1 ? wd_q[1] : 32'hdead), 64'h00100093);

    // Zero count
    clear_log();
    pulse_start(0);
    check("zero_done", 64'(done), 64'd1);
    check("zero_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    check("zero_done_clear", 64'(done), 64'd0);

    // Over capacity; bytes offered in IDLE must not be accepted
    pulse_start(4097);
    check("over_done", 64'(done), 64'd1);
    check("over_error", 64'(error), 64'd1);
    byte_valid = 1'b1;
    byte_data  = 8'h5a;
    repeat (3) @(posedge clk);
    #1;
    check("idle_ready", 64'(byte_ready), 64'd0);
    byte_valid = 1'b0;
    check("over_error_sticky", 64'(error), 64'd1);
    check("over_zero_writes", 64'(wa_q.size()), 64'd0);
    check("over_done_count", 64'(done_n), 64'd2);

    // Random loads with backpressure and ignored starts
    for (int r = 0; r < 4; r++) begin
      fill_random($urandom_range(1, 6));
      run_load(byte_q.size() / 4, 1'b1, 1'b0);
    end

    // Reset after 2 of 4 bytes
    fill_random(4);
    clear_log();
    pulse_start(4);
    send_byte(byte_q[0], 1'b0);
    send_byte(byte_q[1], 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("midreset_no_write", 64'(wa_q.size()), 64'd0);
    fill_random(1);
    run_load(1, 1'b1, 1'b0);

`ifdef INSTR_LOADER_CHECKSUM_EN
    byte_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    run_load(2, 1'b0, 1'b0);
    byte_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    run_load(2, 1'b1, 1'b1);
`endif

    // Full capacity
    fill_random(4096);
    run_load(4096, 1'b0, 1'b0);
    check("last_addr", 64'(wa_q.size() > 0 ? wa_q[$] : 32'hdead), 64'h3ffc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
